// File: rtl/automata_pkg.sv
// Shared constants and types for the cellular-automaton row datapath.
package automata_pkg;

    localparam int unsigned WORD_W    = 20;
    localparam int unsigned ROW_WORDS = 32;
    localparam int unsigned ADDR_W    = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FETCH = 3'd2,
        PAD   = 3'd3,
        FIN   = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/feeder_skid.sv
// One-entry holding register for a RAM word that arrived while the sink was stalled.
module feeder_skid #(
    parameter int unsigned DATA_W = automata_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              unload,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Load wins over unload so a drain and refill in one cycle keeps the entry valid.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/row_word_feeder.sv
// Streams one automaton row from cell RAM into the 41-bit shift buffer,
// with zero padding at both row edges and sink back-pressure.
module row_word_feeder
    import automata_pkg::*;
#(
    parameter int unsigned WORD_W    = automata_pkg::WORD_W,
    parameter int unsigned ROW_WORDS = automata_pkg::ROW_WORDS,
    parameter int unsigned ADDR_W    = automata_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] row_base,
    input  logic              sink_ready,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              sb_clear,
    output logic              sb_shift,
    output logic [WORD_W-1:0] sb_din,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_WORDS - 1);
    localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(ROW_WORDS);

    feeder_state_t     state_q;
    feeder_state_t     state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  sh_cnt_q;
    logic              rd_pend_q;
    logic              busy_q;
    logic              done_q;
    logic              sb_clear_q;
    logic              win_valid_q;
    logic [ADDR_W-1:0] win_idx_q;

    logic              skid_v;
    logic [WORD_W-1:0] skid_d;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_occ_nxt;
    logic              data_shift;
    logic              pad_shift;
    logic              shift_c;
    logic [WORD_W-1:0] din_c;
    logic              issue_c;

    feeder_skid #(
        .DATA_W (WORD_W)
    ) u_skid (
        .clk       (clk),
        .clear_n   (clear_n),
        .load      (skid_load),
        .load_data (mem_rdata),
        .unload    (skid_unload),
        .valid     (skid_v),
        .data      (skid_d)
    );

    // Next state, shift/skid steering and read issue.
    always_comb begin
        state_nxt    = state_q;
        data_shift   = 1'b0;
        pad_shift    = 1'b0;
        din_c        = '0;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_occ_nxt = 1'b0;
        issue_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (sink_ready && skid_v) begin
                    data_shift  = 1'b1;
                    din_c       = skid_d;
                    skid_unload = 1'b1;
                    skid_load   = rd_pend_q;
                end else if (sink_ready && rd_pend_q) begin
                    data_shift = 1'b1;
                    din_c      = mem_rdata;
                end else if (rd_pend_q) begin
                    skid_load = 1'b1;
                end
                // A new read may only be issued if its data is guaranteed a free skid slot.
                skid_occ_nxt = skid_load || (skid_v && !skid_unload);
                issue_c      = (rd_cnt_q < ROW_END) && !skid_occ_nxt;
                if (data_shift && (sh_cnt_q == ROW_LAST)) begin
                    state_nxt = PAD;
                end
            end
            PAD: begin
                // First PAD cycle(s) push the right-edge zero word; the next one lets its window show.
                if (sh_cnt_q == ROW_END) begin
                    pad_shift = sink_ready;
                end else begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign shift_c = data_shift || pad_shift;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            rd_cnt_q    <= '0;
            sh_cnt_q    <= '0;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sb_clear_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_idx_q   <= '0;
        end else begin
            state_q     <= state_nxt;
            busy_q      <= (state_nxt == CLR) || (state_nxt == FETCH) || (state_nxt == PAD);
            done_q      <= (state_nxt == FIN);
            sb_clear_q  <= (state_nxt == CLR);
            rd_pend_q   <= issue_c;
            win_valid_q <= shift_c && (sh_cnt_q != '0);
            if (shift_c && (sh_cnt_q != '0)) begin
                win_idx_q <= ADDR_W'(sh_cnt_q - CNT_W'(1));
            end
            if ((state_q == IDLE) && start) begin
                base_q <= row_base;
            end
            if (state_q == CLR) begin
                rd_cnt_q <= '0;
                sh_cnt_q <= '0;
            end else begin
                if (issue_c) begin
                    rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                end
                if (shift_c) begin
                    sh_cnt_q <= sh_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign mem_rd    = issue_c;
    assign mem_addr  = issue_c ? (base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
    assign sb_shift  = shift_c;
    assign sb_din    = din_c;
    assign sb_clear  = sb_clear_q;
    assign win_valid = win_valid_q;
    assign win_idx   = win_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
